// File: rtl/hdc_pkg.sv
// Shared constants, FSM encoding and pipeline record for the associative search block.
// Combinational definitions only; no latency or flow-control of its own.
// Backpressure: not applicable.
package hdc_pkg;

    localparam int NUM_CLASSES = 8;
    localparam int NUM_FRAMES  = 3;
    localparam int FRAME_W     = 64;
    localparam int DIST_W      = 8;
    localparam int CLS_W       = 3;
    localparam int FIDX_W      = 2;
    localparam int PC_W        = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    // One registered popcount term travelling towards the accumulator.
    typedef struct packed {
        logic [PC_W-1:0]  cnt;
        logic [CLS_W-1:0] cls;
        logic             first;
        logic             last;
    } pc_stage_t;

endpackage

// File: rtl/popcount64.sv
// XOR popcount of two frames (Hamming distance of one frame pair).
// Latency: purely combinational.
// Backpressure: none; result follows the inputs.
module popcount64
    import hdc_pkg::*;
#(
    parameter int FRAME_W = hdc_pkg::FRAME_W,
    parameter int CNT_W   = hdc_pkg::PC_W
) (
    input  logic [FRAME_W-1:0] a,
    input  logic [FRAME_W-1:0] b,
    output logic [CNT_W-1:0]   cnt
);

    logic [FRAME_W-1:0] diff;

    assign diff = a ^ b;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            cnt = cnt + CNT_W'(diff[i]);
        end
    end

endmodule

// File: rtl/assoc_search.sv
// Nearest-class search: streams class frames from an external generator, returns min-Hamming class.
// Latency: result_valid rises 25 edges after the final query beat (24 pair cycles + popcount register).
// Backpressure: query_ready low while searching/holding; result held in DONE until result_ready.
module assoc_search
    import hdc_pkg::*;
#(
    parameter int NUM_CLASSES = hdc_pkg::NUM_CLASSES,
    parameter int NUM_FRAMES  = hdc_pkg::NUM_FRAMES,
    parameter int FRAME_W     = hdc_pkg::FRAME_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      query_valid,
    output logic                      query_ready,
    input  logic [FRAME_W-1:0]        query_frame,
    output logic [hdc_pkg::CLS_W-1:0] frame_id,
    output logic [hdc_pkg::FIDX_W-1:0] frame_index,
    input  logic [FRAME_W-1:0]        class_vec_in,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [hdc_pkg::CLS_W-1:0] result_class,
    output logic [hdc_pkg::DIST_W-1:0] result_dist
);

    localparam logic [CLS_W-1:0]  LAST_CLS = CLS_W'(NUM_CLASSES - 1);
    localparam logic [FIDX_W-1:0] LAST_FRM = FIDX_W'(NUM_FRAMES - 1);

    state_t state, state_nxt;

    logic [FIDX_W-1:0]  beat_cnt;
    logic [FRAME_W-1:0] query_buf [NUM_FRAMES];

    logic [CLS_W-1:0]   cls_q;
    logic [FIDX_W-1:0]  frm_q;
    logic               issuing;

    pc_stage_t          pc_q;
    logic               pc_vld;
    logic [PC_W-1:0]    pc_cnt;

    logic [DIST_W-1:0]  acc;
    logic [DIST_W-1:0]  acc_sum;
    logic [DIST_W-1:0]  best_dist, best_dist_nxt;
    logic [CLS_W-1:0]   best_class, best_class_nxt;
    logic [CLS_W-1:0]   res_class;
    logic [DIST_W-1:0]  res_dist;

    logic beat_acc, last_beat, last_pair, take, search_end;

    assign query_ready  = (state == IDLE) || (state == LOAD);
    assign result_valid = (state == DONE);
    assign result_class = res_class;
    assign result_dist  = res_dist;
    // Pair counters are parked at zero whenever no pair is being issued.
    assign frame_id     = cls_q;
    assign frame_index  = frm_q;

    assign beat_acc  = query_valid && query_ready;
    assign last_beat = beat_acc && (beat_cnt == LAST_FRM);
    assign last_pair = issuing && (cls_q == LAST_CLS) && (frm_q == LAST_FRM);

    assign acc_sum        = (pc_q.first ? '0 : acc) + DIST_W'(pc_q.cnt);
    assign take           = pc_vld && pc_q.last && (acc_sum < best_dist);
    assign best_dist_nxt  = take ? acc_sum : best_dist;
    assign best_class_nxt = take ? pc_q.cls : best_class;
    assign search_end     = pc_vld && pc_q.last && (pc_q.cls == LAST_CLS);

    popcount64 #(
        .FRAME_W (FRAME_W),
        .CNT_W   (PC_W)
    ) u_popcount (
        .a   (query_buf[frm_q]),
        .b   (class_vec_in),
        .cnt (pc_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (beat_acc)     state_nxt = last_beat ? SEARCH : LOAD;
            LOAD:    if (last_beat)    state_nxt = SEARCH;
            SEARCH:  if (search_end)   state_nxt = DONE;
            DONE:    if (result_ready) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Stale query contents are harmless: every frame is rewritten before a search starts.
    always_ff @(posedge clk) begin
        if (beat_acc) begin
            query_buf[beat_cnt] <= query_frame;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            cls_q      <= '0;
            frm_q      <= '0;
            issuing    <= 1'b0;
            pc_q       <= '0;
            pc_vld     <= 1'b0;
            acc        <= '0;
            best_dist  <= '1;
            best_class <= '0;
            res_class  <= '0;
            res_dist   <= '0;
        end else begin
            if (beat_acc) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end

            if (last_beat) begin
                cls_q      <= '0;
                frm_q      <= '0;
                issuing    <= 1'b1;
                pc_vld     <= 1'b0;
                acc        <= '0;
                best_dist  <= '1;
                best_class <= '0;
            end else if (state == SEARCH) begin
                pc_vld <= issuing;
                if (issuing) begin
                    pc_q <= '{cnt:   pc_cnt,
                              cls:   cls_q,
                              first: (frm_q == '0),
                              last:  (frm_q == LAST_FRM)};
                    if (frm_q == LAST_FRM) begin
                        frm_q   <= '0;
                        cls_q   <= last_pair ? '0 : cls_q + 1'b1;
                        issuing <= !last_pair;
                    end else begin
                        frm_q <= frm_q + 1'b1;
                    end
                end
                if (pc_vld) begin
                    acc        <= acc_sum;
                    best_dist  <= best_dist_nxt;
                    best_class <= best_class_nxt;
                end
                if (search_end) begin
                    res_class <= best_class_nxt;
                    res_dist  <= best_dist_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_assoc_search.sv
// Bench for assoc_search: directed table, hand-written reset/hold sequences, randomized queries vs model.
module tb_assoc_search;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        query_valid;
    logic        query_ready;
    logic [63:0] query_frame;
    logic [2:0]  frame_id;
    logic [1:0]  frame_index;
    logic [63:0] class_vec_in;
    logic        result_valid;
    logic        result_ready;
    logic [2:0]  result_class;
    logic [7:0]  result_dist;

    logic [63:0] class_mem [8][3];
    logic [63:0] common_mem [3];
    logic [63:0] qv [3];
    logic        stub;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    // Stub class-vector generator: per-class table, or one shared vector for every class.
    assign class_vec_in = stub ? common_mem[frame_index] : class_mem[frame_id][frame_index];

    assoc_search dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .query_valid  (query_valid),
        .query_ready  (query_ready),
        .query_frame  (query_frame),
        .frame_id     (frame_id),
        .frame_index  (frame_index),
        .class_vec_in (class_vec_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_dist  (result_dist)
    );

    typedef struct {
        string name;
        int    qclass;
        int    flip_f;
        int    flip_b;
        bit    use_stub;
        int    gap;
        int    hold;
        int    exp_c;
        int    exp_d;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: brute-force Hamming distance to every class, first minimum wins.
    task automatic ref_best(output int bc, output int bd);
        bd = 1000;
        bc = 0;
        for (int c = 0; c < 8; c++) begin
            int d = 0;
            for (int f = 0; f < 3; f++) begin
                d += $countones(qv[f] ^ (stub ? common_mem[f] : class_mem[c][f]));
            end
            if (d < bd) begin
                bd = d;
                bc = c;
            end
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, " query_ready"}, query_ready, 1);
        check({tag, " result_valid"}, result_valid, 0);
        check({tag, " result_class"}, result_class, 0);
        check({tag, " result_dist"}, result_dist, 0);
        check({tag, " frame_id"}, frame_id, 0);
        check({tag, " frame_index"}, frame_index, 0);
    endtask

    task automatic send_query(input int gap);
        for (int k = 0; k < 3; k++) begin
            repeat (gap) step();
            query_valid = 1'b1;
            query_frame = qv[k];
            step();
            query_valid = 1'b0;
        end
    endtask

    task automatic run_case(input string name, input int gap, input int hold,
                            input int exp_c, input int exp_d);
        int lat;
        logic [2:0] held_c;
        logic [7:0] held_d;
        send_query(gap);
        check({name, " pair 0"}, {frame_id, frame_index}, 0);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            query_valid = 1'($urandom_range(0, 1));
            query_frame = {$urandom, $urandom};
            step();
            if (n < 24) check({name, " pair seq"}, {frame_id, frame_index}, ((n / 3) << 2) | (n % 3));
            if (result_valid) begin
                lat = n;
                break;
            end
        end
        query_valid = 1'b0;
        check({name, " latency"}, lat, 25);
        check({name, " class"}, result_class, exp_c);
        check({name, " dist"}, result_dist, exp_d);
        held_c = result_class;
        held_d = result_dist;
        for (int h = 0; h < hold; h++) begin
            query_valid = 1'b1;
            query_frame = {$urandom, $urandom};
            step();
            check({name, " hold valid"}, result_valid, 1);
            check({name, " hold query_ready"}, query_ready, 0);
            check({name, " hold result"}, {result_class, result_dist}, {held_c, held_d});
        end
        query_valid  = 1'b0;
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check({name, " back to idle"}, {query_ready, result_valid}, 2'b10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, bd;
        rst_n        = 1'b0;
        query_valid  = 1'b0;
        query_frame  = '0;
        result_ready = 1'b0;
        stub         = 1'b0;
        for (int c = 0; c < 8; c++)
            for (int f = 0; f < 3; f++)
                class_mem[c][f] = {$urandom, $urandom};
        for (int f = 0; f < 3; f++) common_mem[f] = {$urandom, $urandom};

        vecs[0] = '{"class3 exact",    3, -1,  0, 1'b0, 0,  0, 3, 0};
        vecs[1] = '{"class6 flip",     6,  1,  0, 1'b0, 0,  0, 6, 1};
        vecs[2] = '{"stub tie",        0, -1,  0, 1'b1, 0,  0, 0, 0};
        vecs[3] = '{"hold 10",         2, -1,  0, 1'b0, 0, 10, 2, 0};
        vecs[4] = '{"class3 gaps",     3, -1,  0, 1'b0, 2,  0, 3, 0};
        vecs[5] = '{"class6 flip gap", 6,  1,  0, 1'b0, 2,  0, 6, 1};
        vecs[6] = '{"class7 msb flip", 7,  2, 63, 1'b0, 1,  0, 7, 1};

        step();
        check_reset_outs("reset");
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            stub = vecs[i].use_stub;
            for (int f = 0; f < 3; f++)
                qv[f] = stub ? common_mem[f] : class_mem[vecs[i].qclass][f];
            if (vecs[i].flip_f >= 0) qv[vecs[i].flip_f][vecs[i].flip_b] = ~qv[vecs[i].flip_f][vecs[i].flip_b];
            run_case(vecs[i].name, vecs[i].gap, vecs[i].hold, vecs[i].exp_c, vecs[i].exp_d);
            stub = 1'b0;
        end

        // Reset in the middle of a search, then a fresh query must be unaffected.
        for (int f = 0; f < 3; f++) qv[f] = class_mem[5][f];
        send_query(0);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check_reset_outs("mid-search reset");
        step();
        rst_n = 1'b1;
        step();
        for (int f = 0; f < 3; f++) qv[f] = class_mem[3][f];
        run_case("after reset", 0, 0, 3, 0);

        for (int i = 0; i < 20; i++) begin
            int mode = $urandom_range(0, 2);
            int base = $urandom_range(0, 7);
            for (int f = 0; f < 3; f++) begin
                case (mode)
                    0:       qv[f] = {$urandom, $urandom};
                    1:       qv[f] = class_mem[base][f];
                    default: qv[f] = class_mem[$urandom_range(0, 7)][f];
                endcase
            end
            if (mode == 1) begin
                int nflip = $urandom_range(1, 60);
                for (int k = 0; k < nflip; k++) begin
                    int ff = $urandom_range(0, 2);
                    int bb = $urandom_range(0, 63);
                    qv[ff][bb] = ~qv[ff][bb];
                end
            end
            ref_best(bc, bd);
            run_case("random", $urandom_range(0, 2), $urandom_range(0, 3), bc, bd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
